// File: rtl/net_run_ctrl_pkg.sv
// net_run_ctrl_pkg
//   Shared types and constants for the net_proc run sequencer.
//   state_t        : sequencer states (CLEAR, LOAD, START, RUN, RESULT)
//   ERR_IDX        : result index reported on a watchdog timeout
//   NET_NUM_INPUTS : bytes per input image (28x28 grayscale)
package net_run_ctrl_pkg;

    localparam int NET_NUM_INPUTS = 784;

    localparam logic [3:0] ERR_IDX = 4'hF;

    typedef enum logic [2:0] {
        CLEAR,
        LOAD,
        START,
        RUN,
        RESULT
    } state_t;

endpackage

// File: rtl/net_run_wdog.sv
// net_run_wdog
//   Loadable down-counter used as the RUN-state watchdog. Only instantiated when
//   NET_RUN_CTRL_TIMEOUT_EN is defined.
//   clk, rst : clock, synchronous active-high reset
//   load     : reload the counter with TIMEOUT_CYCLES-1 (done on RUN entry)
//   en       : count down while high; counter parks at zero
//   expired  : terminal count reached while enabled
module net_run_wdog #(
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Loaded with T-1 so the flag is raised in the T-th enabled cycle.
    assign expired = en && (cnt == '0);

endmodule

// File: rtl/net_run_ctrl.sv
// net_run_ctrl
//   Sequencer in front of net_proc: clears and loads the data memory from a
//   valid/ready byte stream, pulses start, waits for done and returns the
//   classification index on a valid/ready result port.
//   Optional build macro: NET_RUN_CTRL_TIMEOUT_EN adds a RUN-state watchdog
//   that reports ERR_IDX with res_err=1 when net_proc never finishes.
//
//   state  | meaning
//   CLEAR  | np_mem_rst high for one cycle, count cleared
//   LOAD   | accepting image bytes, one memory write per accepted byte
//   START  | last write in flight; np_start issued on exit
//   RUN    | waiting for a qualified np_done (stale done masked by guard)
//   RESULT | holding result until res_ready
//
//   Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready/in_data     image byte stream
//   res_valid/res_ready           result handshake
//   res_idx, res_err              argmax index / timeout flag
//   busy                          low only in CLEAR and in LOAD with no byte taken
//   np_start, np_done, np_max_idx net_proc control
//   np_mem_rst/we/wdata           net_proc external memory port
module net_run_ctrl
    import net_run_ctrl_pkg::*;
#(
    parameter int NUM_INPUTS     = NET_NUM_INPUTS,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int DONE_GUARD     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_idx,
    output logic       res_err,
    output logic       busy,
    output logic       np_start,
    input  logic       np_done,
    input  logic [3:0] np_max_idx,
    output logic       np_mem_rst,
    output logic       np_mem_we,
    output logic [7:0] np_mem_wdata
);

    localparam int CW = $clog2(NUM_INPUTS + 1);
    localparam int GW = (DONE_GUARD < 1) ? 1 : $clog2(DONE_GUARD + 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(NUM_INPUTS - 1);
    localparam logic [GW-1:0] GUARD_INIT = GW'(DONE_GUARD);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [GW-1:0] guard;
    logic          done_ok;

    // net_proc may still show done from the previous image right after start.
    assign done_ok  = (guard == '0) && np_done;
    assign in_ready = (state == LOAD);

`ifdef NET_RUN_CTRL_TIMEOUT_EN
    logic wdog_expired;

    net_run_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .load   (state == START),
        .en     (state == RUN),
        .expired(wdog_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            cnt          <= '0;
            guard        <= '0;
            np_start     <= 1'b0;
            np_mem_rst   <= 1'b1;
            np_mem_we    <= 1'b0;
            np_mem_wdata <= '0;
            res_valid    <= 1'b0;
            res_idx      <= '0;
            res_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            np_mem_we <= 1'b0;
            case (state)
                CLEAR: begin
                    np_mem_rst <= 1'b0;
                    cnt        <= '0;
                    busy       <= 1'b0;
                    state      <= LOAD;
                end
                LOAD: begin
                    if (in_valid) begin
                        np_mem_we    <= 1'b1;
                        np_mem_wdata <= in_data;
                        cnt          <= cnt + 1'b1;
                        busy         <= 1'b1;
                        if (cnt == LAST_CNT) begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    // The final write is on the port this cycle; start follows it.
                    np_start <= 1'b1;
                    guard    <= GUARD_INIT;
                    state    <= RUN;
                end
                RUN: begin
                    np_start <= 1'b0;
                    if (guard != '0) begin
                        guard <= guard - 1'b1;
                    end
                    if (done_ok) begin
                        res_idx   <= np_max_idx;
                        res_err   <= 1'b0;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
`ifdef NET_RUN_CTRL_TIMEOUT_EN
                    else if (wdog_expired) begin
                        res_idx   <= ERR_IDX;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                        state     <= RESULT;
                    end
`endif
                end
                RESULT: begin
                    if (res_ready) begin
                        res_valid  <= 1'b0;
                        np_mem_rst <= 1'b1;
                        busy       <= 1'b0;
                        state      <= CLEAR;
                    end
                end
                default: begin
                    np_mem_rst <= 1'b1;
                    busy       <= 1'b0;
                    state      <= CLEAR;
                end
            endcase
        end
    end

endmodule
